// File: rtl/lane_arbiter_8b.sv
// Four-lane byte arbiter: rotating-priority grant of one 4-byte word at a time to a single 8b output.
// Latency 1 cycle input byte to output; per-lane valid stalls hold the word, 8 stalled cycles abort it.
module lane_arbiter_8b (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        enable_in,
  input  logic [3:0]  req_in,
  input  logic [3:0]  valid_in,
  input  logic [31:0] data_in,
  output logic [3:0]  grant_out,
  output logic [1:0]  lane_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        first_out,
  output logic        word_done,
  output logic        abort_out
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nxt;
  logic [1:0]  prio, prio_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [2:0]  stall_cnt, stall_cnt_nxt;
  logic [3:0]  grant_nxt;
  logic [1:0]  lane_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt, first_nxt, done_nxt, abort_nxt;
  logic [1:0]  pick_idle, pick_next, lane_inc;
  logic [7:0]  lane_byte;

  // First requesting lane scanning p, p+1, ... (2-bit index wraps mod 4).
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] req);
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (req[idx]) pick = idx;
    end
  endfunction

  assign lane_inc  = lane_out + 2'd1;
  assign pick_idle = pick(prio, req_in);
  assign pick_next = pick(lane_inc, req_in);
  assign lane_byte = data_in[{lane_out, 3'b000} +: 8];

  always_comb begin
    state_nxt     = state;
    prio_nxt      = prio;
    byte_cnt_nxt  = byte_cnt;
    stall_cnt_nxt = stall_cnt;
    grant_nxt     = grant_out;
    lane_nxt      = lane_out;
    data_nxt      = data_out;
    valid_nxt     = 1'b0;
    first_nxt     = 1'b0;
    done_nxt      = 1'b0;
    abort_nxt     = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        if (enable_in && |req_in) begin
          state_nxt     = XFER;
          grant_nxt     = 4'b0001 << pick_idle;
          lane_nxt      = pick_idle;
          byte_cnt_nxt  = 2'd0;
          stall_cnt_nxt = 3'd0;
        end
      end
      XFER: begin
        if (valid_in[lane_out]) begin
          data_nxt      = lane_byte;
          valid_nxt     = 1'b1;
          first_nxt     = (byte_cnt == 2'd0);
          done_nxt      = (byte_cnt == 2'd3);
          stall_cnt_nxt = 3'd0;
          byte_cnt_nxt  = byte_cnt + 2'd1;
          // Word complete: rotate priority and re-arbitrate on the same edge.
          if (byte_cnt == 2'd3) begin
            prio_nxt = lane_inc;
            if (enable_in && |req_in) begin
              grant_nxt = 4'b0001 << pick_next;
              lane_nxt  = pick_next;
            end else begin
              state_nxt = IDLE;
              grant_nxt = 4'b0000;
            end
          end
        end else if (stall_cnt == 3'd7) begin
          abort_nxt     = 1'b1;
          grant_nxt     = 4'b0000;
          prio_nxt      = lane_inc;
          byte_cnt_nxt  = 2'd0;
          stall_cnt_nxt = 3'd0;
          state_nxt     = IDLE;
        end else begin
          stall_cnt_nxt = stall_cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 2'd0;
      byte_cnt  <= 2'd0;
      stall_cnt <= 3'd0;
      grant_out <= 4'b0000;
      lane_out  <= 2'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      word_done <= 1'b0;
      abort_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      byte_cnt  <= byte_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
      grant_out <= grant_nxt;
      lane_out  <= lane_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      first_out <= first_nxt;
      word_done <= done_nxt;
      abort_out <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_lane_arbiter_8b.sv
// Scoreboarded bench for lane_arbiter_8b: directed scenarios followed by random traffic,
// checked against a word-level model of lane ownership, bytes taken and stall run length.
module tb_lane_arbiter_8b;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic        enable_in = 1'b0;
  logic [3:0]  req_in = 4'h0;
  logic [3:0]  valid_in = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  grant_out;
  logic [1:0]  lane_out;
  logic [7:0]  data_out;
  logic        valid_out, first_out, word_done, abort_out;

  lane_arbiter_8b dut (
    .clk_4f(clk_4f), .reset(reset), .enable_in(enable_in), .req_in(req_in),
    .valid_in(valid_in), .data_in(data_in), .grant_out(grant_out), .lane_out(lane_out),
    .data_out(data_out), .valid_out(valid_out), .first_out(first_out),
    .word_done(word_done), .abort_out(abort_out)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    int grant; int lane; bit valid; bit first; bit done; bit abort; bit data_chk; int data;
  } rec_t;
  typedef struct { int data; bit valid; bit first; bit done; bit abort; } ev_t;

  rec_t exp_q[$];
  ev_t  ev_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: owner of the datapath (-1 idle), bytes taken of the word, stall run length.
  int m_owner = -1, m_prio = 0, m_taken = 0, m_stalls = 0, m_lane = 0;

  function automatic int pick(input int p, input logic [3:0] req);
    for (int i = 0; i < 4; i++)
      if (req[(p + i) % 4]) return (p + i) % 4;
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_4f) begin
    rec_t r;
    ev_t  e;
    int   l;
    r = '{default: 0};
    e = '{default: 0};
    if (reset) begin
      m_owner = -1; m_prio = 0; m_taken = 0; m_stalls = 0; m_lane = 0;
      r.data_chk = 1'b1;
      r.data = 0;
    end else if (m_owner < 0) begin
      if (enable_in && req_in != 4'h0) begin
        m_owner = pick(m_prio, req_in);
        m_lane = m_owner; m_taken = 0; m_stalls = 0;
      end
    end else begin
      l = m_owner;
      if (valid_in[l]) begin
        r.valid = 1'b1; r.first = (m_taken == 0); r.done = (m_taken == 3);
        r.data_chk = 1'b1; r.data = int'((data_in >> (8 * l)) & 32'hFF);
        e.valid = 1'b1; e.first = r.first; e.done = r.done; e.data = r.data;
        ev_q.push_back(e);
        m_taken++; m_stalls = 0;
        if (m_taken == 4) begin
          m_taken = 0;
          m_prio = (l + 1) % 4;
          if (enable_in && req_in != 4'h0) begin
            m_owner = pick(m_prio, req_in);
            m_lane = m_owner;
          end else begin
            m_owner = -1;
          end
        end
      end else begin
        m_stalls++;
        if (m_stalls == 8) begin
          r.abort = 1'b1; e.abort = 1'b1;
          ev_q.push_back(e);
          m_prio = (l + 1) % 4; m_owner = -1; m_taken = 0; m_stalls = 0;
        end
      end
    end
    r.grant = (m_owner < 0) ? 0 : (1 << m_owner);
    r.lane = m_lane;
    exp_q.push_back(r);
  end

  // Monitor: per-cycle control outputs, plus the event stream whenever the DUT emits a byte or abort.
  always @(negedge clk_4f) begin
    rec_t r;
    ev_t  e;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check("grant_out", int'(grant_out), r.grant);
      check("lane_out", int'(lane_out), r.lane);
      check("valid_out", int'(valid_out), int'(r.valid));
      check("first_out", int'(first_out), int'(r.first));
      check("word_done", int'(word_done), int'(r.done));
      check("abort_out", int'(abort_out), int'(r.abort));
      if (r.data_chk) check("data_out", int'(data_out), r.data);
    end
    if (valid_out || abort_out) begin
      if (ev_q.size() == 0) begin
        check("unexpected_output", int'({valid_out, abort_out}), 0);
      end else begin
        e = ev_q.pop_front();
        check("ev_valid", int'(valid_out), int'(e.valid));
        check("ev_abort", int'(abort_out), int'(e.abort));
        if (e.valid) begin
          check("ev_data", int'(data_out), e.data);
          check("ev_first", int'(first_out), int'(e.first));
          check("ev_done", int'(word_done), int'(e.done));
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit en, input logic [3:0] req,
                       input logic [3:0] vld, input logic [31:0] dat);
    @(negedge clk_4f);
    reset = rst; enable_in = en; req_in = req; valid_in = vld; data_in = dat;
  endtask

  initial begin
    logic [3:0] stall_pat [6];
    stall_pat = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4};

    drive(1, 0, 4'h0, 4'h0, $urandom);
    drive(1, 0, 4'h0, 4'h0, $urandom);

    // Single lane word AA BB CC DD.
    drive(0, 1, 4'h1, 4'h0, $urandom);
    drive(0, 1, 4'h0, 4'h1, 32'h000000AA);
    drive(0, 1, 4'h0, 4'h1, 32'h000000BB);
    drive(0, 1, 4'h0, 4'h1, 32'h000000CC);
    drive(0, 1, 4'h0, 4'h1, 32'h000000DD);
    drive(0, 1, 4'h0, 4'h0, $urandom);
    drive(0, 1, 4'h0, 4'h0, $urandom);

    // All lanes requesting: round-robin back-to-back words.
    for (int i = 0; i < 24; i++) drive(0, 1, 4'hF, 4'hF, $urandom);
    for (int i = 0; i < 5; i++) drive(0, 1, 4'h0, 4'hF, $urandom);

    // Lane 2 with a two-cycle gap after byte 1.
    drive(0, 1, 4'h4, 4'h0, $urandom);
    for (int i = 0; i < 6; i++) drive(0, 1, 4'h0, stall_pat[i], $urandom);
    drive(0, 1, 4'h0, 4'h0, $urandom);

    // Lane 1 stalls out after byte 0; lanes 1 and 2 then compete.
    drive(0, 1, 4'h2, 4'h0, $urandom);
    drive(0, 1, 4'h0, 4'h2, $urandom);
    for (int i = 0; i < 9; i++) drive(0, 1, 4'h6, 4'h0, $urandom);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'h0, 4'hF, $urandom);
    drive(0, 1, 4'h0, 4'h0, $urandom);

    // Reset on byte 2 of a word, then all lanes request.
    drive(0, 1, 4'hF, 4'h0, $urandom);
    drive(0, 1, 4'h0, 4'hF, $urandom);
    drive(0, 1, 4'h0, 4'hF, $urandom);
    drive(1, 1, 4'h0, 4'hF, $urandom);
    for (int i = 0; i < 6; i++) drive(0, 1, 4'hF, 4'hF, $urandom);
    for (int i = 0; i < 5; i++) drive(0, 1, 4'h0, 4'hF, $urandom);

    // Enable dropped during byte 1: word finishes, no new grant until enable returns.
    drive(0, 1, 4'h1, 4'h0, $urandom);
    drive(0, 1, 4'h0, 4'h1, $urandom);
    drive(0, 0, 4'hF, 4'h1, $urandom);
    drive(0, 0, 4'hF, 4'h1, $urandom);
    drive(0, 0, 4'hF, 4'h1, $urandom);
    for (int i = 0; i < 3; i++) drive(0, 0, 4'hF, 4'hF, $urandom);
    for (int i = 0; i < 6; i++) drive(0, 1, 4'hF, 4'hF, $urandom);

    // Random traffic with occasional resets and periodic long valid droughts.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] vld;
      vld = ((i % 300) < 12) ? 4'h0 : 4'($urandom | $urandom);
      drive($urandom_range(0, 249) == 0, $urandom_range(0, 9) != 0,
            4'($urandom), vld, $urandom);
    end
    drive(0, 0, 4'h0, 4'h0, $urandom);
    @(negedge clk_4f);
    @(negedge clk_4f);
    check("events_drained", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
